spi_slave_cfg: RTL and testbench

SPI_SLAVE_CFG -- requirements
Module: spi_slave_cfg

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync2.sv | 31 +++
 rtl/spi_slave_cfg.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_slave_cfg.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state type and {CPOL,CPHA} mode encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_pkg;

  // Frame state: IDLE while chip select is high, ACTIVE while it is low.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // SPI modes encoded as {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Modes with CPHA=1 sample mosi on the trailing sclk edge.
  function automatic logic samples_on_trailing(input logic [1:0] mode);
    return (mode == MODE1) || (mode == MODE3);
  endfunction

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for one asynchronous input bit, with a reset level.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none; samples every clk.
//
// Ports:
//   clk  - system clock (rising edge)
//   rst  - synchronous active-low reset; both flops load RST_VAL
//   d_i  - asynchronous input
//   q_o  - synchronised output
module spi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/spi_slave_cfg.sv
// Configurable SPI slave (mode, word width, bit order) with TX holding register.
// Latency: 3 clk from sclk/cs pins to internal action; rx_valid 1 clk after the last sample edge.
// Backpressure: none on SPI; tx_load accepted only while tx_ready is high (or at a word-start load).
//
// Ports:
//   clk, rst          - system clock, synchronous active-low reset
//   sclk, cs, mosi    - asynchronous SPI inputs (cs active-low)
//   miso              - registered serial output, 0 while idle
//   tx_data, tx_load  - next word to transmit and its write strobe
//   tx_ready          - TX holding register empty
//   rx_data, rx_valid - last complete received word and its one-cycle update pulse
//   busy              - frame in progress (FSM ACTIVE)
//   underrun          - pulse: a word began with the holding register empty
//   abort             - pulse: cs rose with a partial word in flight
module spi_slave_cfg
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             underrun,
  output logic             abort
);

  localparam int unsigned     CNT_W        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH - 1);
  localparam logic [1:0]       MODE        = {CPOL, CPHA};
  localparam logic             SAMPLE_TRAIL = samples_on_trailing(MODE);

  // ---------------------------------------------------------------------------
  // Input synchronisers (reset to idle bus levels)
  // ---------------------------------------------------------------------------
  logic sclk_s;
  logic cs_s;
  logic mosi_s;

  spi_sync2 #(.RST_VAL(CPOL)) u_sync_sclk (
    .clk (clk),
    .rst (rst),
    .d_i (sclk),
    .q_o (sclk_s)
  );

  spi_sync2 #(.RST_VAL(1'b1)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d_i (cs),
    .q_o (cs_s)
  );

  spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d_i (mosi),
    .q_o (mosi_s)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic             sclk_prev_q;
  logic             cs_prev_q;
  logic [1:0]       settle_q;    // counts clk after reset until the cs synchroniser holds real samples
  logic             armed_q;     // a genuine cs-high has been seen since reset
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic [WIDTH-1:0] hold_q;
  logic             tx_ready_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             underrun_q;
  logic             abort_q;
  logic             und_pend_q;  // continuation word was loaded empty; report when its first bit is clocked
  logic             miso_q;

  // ---------------------------------------------------------------------------
  // Edge detection and next-value helpers
  // ---------------------------------------------------------------------------
  logic             lead_edge;
  logic             trail_edge;
  logic             sample_edge;
  logic             shift_edge;
  logic             cs_fall;
  logic             cs_rise;
  logic             word_end;
  logic             word_start;
  logic [WIDTH-1:0] rx_shift_d;
  logic [WIDTH-1:0] load_d;

  function automatic logic tx_first(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] tx_rest(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  always_comb begin
    lead_edge   = (sclk_s != CPOL) && (sclk_prev_q == CPOL);
    trail_edge  = (sclk_s == CPOL) && (sclk_prev_q != CPOL);
    sample_edge = SAMPLE_TRAIL ? trail_edge : lead_edge;
    shift_edge  = SAMPLE_TRAIL ? lead_edge  : trail_edge;

    // A fall is only trusted once cs has been seen high after reset, so a
    // master already holding cs low cannot start a frame mid-stream.
    cs_fall = armed_q && cs_prev_q && !cs_s;
    cs_rise = !cs_prev_q && cs_s;

    word_end   = (state_q == ACTIVE) && !cs_rise && sample_edge && (cnt_q == CNT_LAST);
    word_start = ((state_q == IDLE) && cs_fall) || word_end;

    if (MSB_FIRST) begin
      rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
    end else begin
      rx_shift_d = {mosi_s, rx_shift_q[WIDTH-1:1]};
    end

    // An empty holding register transmits zeros.
    load_d = tx_ready_q ? '0 : hold_q;
  end

  // ---------------------------------------------------------------------------
  // FSM, datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b1;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      tx_ready_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      und_pend_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;

      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end
      if ((settle_q == 2'd2) && cs_s) begin
        armed_q <= 1'b1;
      end

      // Holding register: a load coinciding with a word start still captures,
      // because the shift register takes the old value in the same cycle.
      if (tx_load && (tx_ready_q || word_start)) begin
        hold_q     <= tx_data;
        tx_ready_q <= 1'b0;
      end else if (word_start) begin
        tx_ready_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q    <= ACTIVE;
            cnt_q      <= '0;
            und_pend_q <= 1'b0;
            underrun_q <= tx_ready_q;
            if (SAMPLE_TRAIL) begin
              // First bit goes out on the first leading edge.
              tx_shift_q <= load_d;
            end else begin
              // First bit must be on the wire before the first leading edge.
              miso_q     <= tx_first(load_d);
              tx_shift_q <= tx_rest(load_d);
            end
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            state_q    <= IDLE;
            miso_q     <= 1'b0;
            abort_q    <= (cnt_q != '0);
            cnt_q      <= '0;
            und_pend_q <= 1'b0;
          end else if (sample_edge) begin
            rx_shift_q <= rx_shift_d;
            if (und_pend_q) begin
              underrun_q <= 1'b1;
              und_pend_q <= 1'b0;
            end
            if (cnt_q == CNT_LAST) begin
              cnt_q      <= '0;
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
              // The next word's first bit leaves on the following shift edge
              // in both phases, so the full word is loaded unshifted.
              tx_shift_q <= load_d;
              und_pend_q <= tx_ready_q;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (shift_edge) begin
            miso_q     <= tx_first(tx_shift_q);
            tx_shift_q <= tx_rest(tx_shift_q);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso     = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == ACTIVE);
  assign underrun = underrun_q;
  assign abort    = abort_q;

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Directed bench for spi_slave_cfg: instance 0 is mode 0 MSB-first, instance 1 is mode 3 LSB-first.
// Received words are checked by a scoreboard queue; miso words and pulse counts are checked inline.
module tb_spi_slave_cfg;

  localparam int HALF = 6;   // clk cycles per sclk phase

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sclk;
  logic [1:0] cs;
  logic [1:0] mosi;
  logic [1:0] miso;
  logic [1:0] tx_load;
  logic [1:0] tx_ready;
  logic [1:0] rx_valid;
  logic [1:0] busy;
  logic [1:0] underrun;
  logic [1:0] abort;
  logic [7:0] tx_data0, tx_data1;
  logic [7:0] rx_data0, rx_data1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  int rxv0 = 0, rxv1 = 0;
  int und0 = 0;
  int abt0 = 0, abt1 = 0;

  always #5 clk = ~clk;

  spi_slave_cfg #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .sclk(sclk[0]), .cs(cs[0]), .mosi(mosi[0]), .miso(miso[0]),
    .tx_data(tx_data0), .tx_load(tx_load[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx_data0), .rx_valid(rx_valid[0]), .busy(busy[0]),
    .underrun(underrun[0]), .abort(abort[0])
  );

  spi_slave_cfg #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .sclk(sclk[1]), .cs(cs[1]), .mosi(mosi[1]), .miso(miso[1]),
    .tx_data(tx_data1), .tx_load(tx_load[1]), .tx_ready(tx_ready[1]),
    .rx_data(rx_data1), .rx_valid(rx_valid[1]), .busy(busy[1]),
    .underrun(underrun[1]), .abort(abort[1])
  );

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops on rx_valid, pulse counters.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rx_valid[0]) begin
      rxv0++;
      checks++;
      assert (exp_q0.size() > 0) else begin
        errors++;
        $error("FAIL rx0_unexpected: observed rx_data=%02h expected no rx_valid", rx_data0);
      end
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check_w("rx0_word", rx_data0, e);
      end
    end
    if (rx_valid[1]) begin
      rxv1++;
      checks++;
      assert (exp_q1.size() > 0) else begin
        errors++;
        $error("FAIL rx1_unexpected: observed rx_data=%02h expected no rx_valid", rx_data1);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check_w("rx1_word", rx_data1, e);
      end
    end
    if (underrun[0]) und0++;
    if (abort[0])    abt0++;
    if (abort[1])    abt1++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int d, input logic [7:0] v);
    @(negedge clk);
    if (d == 0) tx_data0 = v; else tx_data1 = v;
    tx_load[d] = 1'b1;
    @(negedge clk);
    tx_load[d] = 1'b0;
  endtask

  task automatic cs_fall(input int d);
    cs[d] = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_rise(input int d);
    wait_clks(HALF);
    cs[d] = 1'b1;
    wait_clks(2 * HALF);
  endtask

  // Master: shifts nb bits of w in the instance's bit order, returns miso bits in mi.
  task automatic spi_bits(input int d, input logic [7:0] w, input int nb, output logic [7:0] mi);
    int idx;
    mi = '0;
    for (int k = 0; k < nb; k++) begin
      idx = (d == 0) ? 7 - k : k;
      if (d == 0) begin
        mosi[0] = w[idx];
        wait_clks(HALF);
        mi[idx] = miso[0];
        sclk[0] = 1'b1;
        wait_clks(HALF);
        sclk[0] = 1'b0;
      end else begin
        sclk[1] = 1'b0;
        mosi[1] = w[idx];
        wait_clks(HALF);
        mi[idx] = miso[1];
        sclk[1] = 1'b1;
        wait_clks(HALF);
      end
    end
  endtask

  task automatic spi_word(input int d, input logic [7:0] w, output logic [7:0] mi);
    if (d == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
    spi_bits(d, w, 8, mi);
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int b_rxv, b_und, b_abt;

    rst      = 1'b0;
    sclk     = 2'b10;
    cs       = 2'b11;
    mosi     = 2'b00;
    tx_load  = 2'b00;
    tx_data0 = 8'h00;
    tx_data1 = 8'h00;

    // Reset values
    wait_clks(3);
    check_b("reset_tx_ready", tx_ready[0], 1'b1);
    check_w("reset_rx_data", rx_data0, 8'h00);
    check_b("reset_busy", busy[0], 1'b0);
    check_b("reset_miso", miso[0], 1'b0);
    check_b("reset_rx_valid", rx_valid[0], 1'b0);
    rst = 1'b1;
    wait_clks(8);

    // Mode 0 MSB-first: receive BD, transmit 5A; second load while full is ignored
    b_rxv = rxv0; b_und = und0; b_abt = abt0;
    load(0, 8'h5A);
    load(0, 8'hFF);
    check_b("tx_ready_after_load", tx_ready[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      sclk[0] = 1'b1; wait_clks(HALF);
      sclk[0] = 1'b0; wait_clks(HALF);
    end
    check_b("idle_sclk_busy", busy[0], 1'b0);
    cs_fall(0);
    check_b("busy_active", busy[0], 1'b1);
    check_b("tx_ready_after_start", tx_ready[0], 1'b1);
    spi_word(0, 8'hBD, mi);
    cs_rise(0);
    check_w("m0_miso_word", mi, 8'h5A);
    check_b("busy_idle", busy[0], 1'b0);
    check_b("miso_idle", miso[0], 1'b0);
    check_i("m0_abort_cnt", abt0 - b_abt, 0);
    check_i("m0_rx_valid_cnt", rxv0 - b_rxv, 1);
    check_i("m0_underrun_cnt", und0 - b_und, 0);

    // Mode 3 LSB-first: receive BD, transmit C3
    b_rxv = rxv1; b_abt = abt1;
    load(1, 8'hC3);
    cs_fall(1);
    spi_word(1, 8'hBD, mi);
    cs_rise(1);
    check_w("m3_miso_word", mi, 8'hC3);
    check_i("m3_rx_valid_cnt", rxv1 - b_rxv, 1);
    check_i("m3_abort_cnt", abt1 - b_abt, 0);

    // Abort after 5 bits, then a clean frame
    b_rxv = rxv0; b_abt = abt0;
    load(0, 8'h11);
    cs_fall(0);
    spi_bits(0, 8'hFF, 5, mi);
    cs_rise(0);
    check_i("abort_cnt", abt0 - b_abt, 1);
    check_i("abort_rx_valid_cnt", rxv0 - b_rxv, 0);
    check_w("abort_rx_data_kept", rx_data0, 8'hBD);
    load(0, 8'h22);
    cs_fall(0);
    spi_word(0, 8'h96, mi);
    cs_rise(0);
    check_w("post_abort_miso", mi, 8'h22);
    check_i("post_abort_rx_valid_cnt", rxv0 - b_rxv, 1);

    // Back-to-back words, only the first loaded
    b_rxv = rxv0; b_und = und0;
    load(0, 8'hA7);
    cs_fall(0);
    spi_word(0, 8'h12, mi);
    spi_word(0, 8'h34, mi2);
    cs_rise(0);
    check_w("b2b_miso_w1", mi, 8'hA7);
    check_w("b2b_miso_w2", mi2, 8'h00);
    check_i("b2b_rx_valid_cnt", rxv0 - b_rxv, 2);
    check_i("b2b_underrun_cnt", und0 - b_und, 1);

    // Reset mid-frame, cs held low across release, then a fresh frame
    b_abt = abt0;
    load(0, 8'h55);
    cs_fall(0);
    spi_bits(0, 8'hFF, 3, mi);
    rst = 1'b0;
    wait_clks(3);
    check_b("midrst_tx_ready", tx_ready[0], 1'b1);
    check_w("midrst_rx_data", rx_data0, 8'h00);
    check_b("midrst_busy", busy[0], 1'b0);
    check_b("midrst_miso", miso[0], 1'b0);
    check_b("midrst_rx_valid", rx_valid[0], 1'b0);
    rst = 1'b1;
    wait_clks(10);
    check_b("cs_low_after_rst_busy", busy[0], 1'b0);
    cs[0] = 1'b1;
    wait_clks(2 * HALF);
    b_und = und0;
    cs_fall(0);
    spi_word(0, 8'h3C, mi);
    cs_rise(0);
    check_w("post_rst_miso_empty", mi, 8'h00);
    check_i("post_rst_underrun_cnt", und0 - b_und, 1);
    check_i("midrst_abort_cnt", abt0 - b_abt, 0);

    wait_clks(4);
    check_i("sb0_drained", exp_q0.size(), 0);
    check_i("sb1_drained", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
